// File: rtl/l2_arbiter_fsm_pkg.sv
// Shared LC-3b memory-system types for the L2 port arbiter.
//   lc3b_word    : 16-bit address word
//   lc3b_burst   : 128-bit cache line burst
//   arb_state_t  : arbiter FSM state encoding
//   ARB_STARVE_W : width of the IF starvation counter
package lc3b_types;

   typedef logic [15:0]  lc3b_word;
   typedef logic [127:0] lc3b_burst;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2
   } arb_state_t;

   localparam int ARB_STARVE_W = 4;

endpackage

// File: rtl/l2_arbiter_fsm_starve_counter.sv
// Saturating counter of consecutive MEM grants taken while IF was waiting.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   clr        : clear to zero (takes priority over inc)
//   inc        : increment, saturating at LIMIT
//   at_limit   : count has reached LIMIT (IF must be granted next)
module arb_starve_counter
   import lc3b_types::*;
#(
   parameter int LIMIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic inc,
   output logic at_limit
);

   localparam logic [ARB_STARVE_W-1:0] LIM = ARB_STARVE_W'(LIMIT);

   logic [ARB_STARVE_W-1:0] cnt;

   assign at_limit = (cnt == LIM);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                cnt <= '0;
      else if (clr)             cnt <= '0;
      else if (inc && !at_limit) cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/l2_arbiter_fsm.sv
// Arbiter sharing the single L2 port between the IF and MEM L1 caches.
// MEM has priority; after STARVE_LIMIT consecutive MEM grants with IF
// pending, IF is forced. A grant is held until l2_resp or until the
// granted requester drops both strobes.
// Ports:
//   clk, reset              : clock, asynchronous active-high reset
//   IF_*  / MEM_*           : L1 request side (address, read, write, wdata)
//   l2_resp, l2_rdata       : L2 completion and read burst
//   l2i_resp, l2i_rdata     : response routed to the IF cache
//   l2d_resp, l2d_rdata     : response routed to the MEM cache
//   l2_address/read/write/wdata : request driven to L2
module l2_arbiter_fsm
   import lc3b_types::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic      clk,
   input  logic      reset,
   input  lc3b_word  IF_address,
   input  logic      IF_read,
   input  logic      IF_write,
   input  lc3b_burst IF_wdata,
   input  lc3b_word  MEM_address,
   input  logic      MEM_read,
   input  logic      MEM_write,
   input  lc3b_burst MEM_wdata,
   input  logic      l2_resp,
   input  lc3b_burst l2_rdata,
   output logic      l2i_resp,
   output lc3b_burst l2i_rdata,
   output logic      l2d_resp,
   output lc3b_burst l2d_rdata,
   output lc3b_word  l2_address,
   output logic      l2_read,
   output logic      l2_write,
   output lc3b_burst l2_wdata
);

   arb_state_t state;
   logic       if_req, mem_req, at_limit, starved;
   logic       cnt_clr, cnt_inc;

   assign if_req  = IF_read  | IF_write;
   assign mem_req = MEM_read | MEM_write;
   assign starved = if_req & at_limit;

   // Counter moves only on grant decisions taken in IDLE.
   always_comb begin
      cnt_clr = 1'b0;
      cnt_inc = 1'b0;
      if (state == IDLE) begin
         if (starved)      cnt_clr = 1'b1;
         else if (mem_req) begin
            cnt_inc = if_req;
            cnt_clr = !if_req;
         end
         else if (if_req)  cnt_clr = 1'b1;
      end
   end

   arb_starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
      .clk      (clk),
      .reset    (reset),
      .clr      (cnt_clr),
      .inc      (cnt_inc),
      .at_limit (at_limit)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else begin
         case (state)
            IDLE: begin
               if (starved)      state <= SERVE_I;
               else if (mem_req) state <= SERVE_D;
               else if (if_req)  state <= SERVE_I;
            end
            // Leave on completion or when the owner abandons its request.
            SERVE_I: if (l2_resp || !if_req)  state <= IDLE;
            SERVE_D: if (l2_resp || !mem_req) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Live passthrough of the granted side; everything zero otherwise.
   always_comb begin
      l2i_resp   = 1'b0;
      l2i_rdata  = '0;
      l2d_resp   = 1'b0;
      l2d_rdata  = '0;
      l2_address = '0;
      l2_read    = 1'b0;
      l2_write   = 1'b0;
      l2_wdata   = '0;
      case (state)
         SERVE_I: begin
            l2_address = IF_address;
            l2_read    = IF_read;
            l2_write   = IF_write;
            l2_wdata   = IF_wdata;
            l2i_resp   = l2_resp;
            l2i_rdata  = l2_rdata;
         end
         SERVE_D: begin
            l2_address = MEM_address;
            l2_read    = MEM_read;
            l2_write   = MEM_write;
            l2_wdata   = MEM_wdata;
            l2d_resp   = l2_resp;
            l2d_rdata  = l2_rdata;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_l2_arbiter_fsm.sv
// Self-checking bench for l2_arbiter_fsm. Expected grants are queued as
// requests are driven and popped when the DUT raises an L2 strobe.
module tb_l2_arbiter_fsm;

   logic         clk = 1'b0;
   logic         reset;
   logic [15:0]  IF_address, MEM_address, l2_address;
   logic         IF_read, IF_write, MEM_read, MEM_write;
   logic [127:0] IF_wdata, MEM_wdata, l2_rdata, l2_wdata;
   logic         l2_resp, l2i_resp, l2d_resp, l2_read, l2_write;
   logic [127:0] l2i_rdata, l2d_rdata;

   int errors = 0;
   int checks = 0;

   typedef struct {
      bit           side_if;
      logic [15:0]  addr;
      logic         rd;
      logic         wr;
      logic [127:0] wdata;
   } grant_t;

   grant_t sb_q[$];

   localparam logic [127:0] RD_A5 = {16{8'hA5}};
   localparam logic [127:0] RD_3C = {16{8'h3C}};

   l2_arbiter_fsm #(.STARVE_LIMIT(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .IF_address  (IF_address),
      .IF_read     (IF_read),
      .IF_write    (IF_write),
      .IF_wdata    (IF_wdata),
      .MEM_address (MEM_address),
      .MEM_read    (MEM_read),
      .MEM_write   (MEM_write),
      .MEM_wdata   (MEM_wdata),
      .l2_resp     (l2_resp),
      .l2_rdata    (l2_rdata),
      .l2i_resp    (l2i_resp),
      .l2i_rdata   (l2i_rdata),
      .l2d_resp    (l2d_resp),
      .l2d_rdata   (l2d_rdata),
      .l2_address  (l2_address),
      .l2_read     (l2_read),
      .l2_write    (l2_write),
      .l2_wdata    (l2_wdata)
   );

   always #5 clk = ~clk;

   // A single requester must never assert read and write together.
   always @(negedge clk) begin
      if ((IF_read && IF_write) || (MEM_read && MEM_write)) begin
         errors++;
         $display("FAIL illegal_rw: IF r/w=%b%b MEM r/w=%b%b", IF_read, IF_write, MEM_read, MEM_write);
      end
   end

   function automatic grant_t mk(input bit s, input logic [15:0] a, input logic r,
                                 input logic w, input logic [127:0] d);
      grant_t g;
      g.side_if = s; g.addr = a; g.rd = r; g.wr = w; g.wdata = d;
      return g;
   endfunction

   // Scoreboard consumer: wait for a strobe within budget cycles, compare it
   // to the oldest expected grant, complete it with l2_resp and confirm the
   // response routing and the following IDLE cycle.
   task automatic sb_pop_grant(input string tag, input logic [127:0] rdata, input int budget);
      grant_t e;
      bit     seen = 0;
      for (int c = 0; c < budget && !seen; c++) begin
         @(negedge clk); #1;
         if (l2_read || l2_write) seen = 1;
      end
      checks++;
      if (!seen || sb_q.size() == 0) begin
         errors++;
         $display("FAIL %s grant_timeout: strobe seen=%0d queued=%0d", tag, seen, sb_q.size());
         return;
      end
      e = sb_q.pop_front();
      checks++;
      if ({l2_address, l2_read, l2_write, l2_wdata} !== {e.addr, e.rd, e.wr, e.wdata}) begin
         errors++;
         $display("FAIL %s grant: got addr=%h r=%b w=%b wd=%h, want addr=%h r=%b w=%b wd=%h",
                  tag, l2_address, l2_read, l2_write, l2_wdata, e.addr, e.rd, e.wr, e.wdata);
      end
      l2_resp = 1'b1; l2_rdata = rdata; #1;
      checks++;
      if (e.side_if) begin
         if ({l2i_resp, l2i_rdata, l2d_resp, l2d_rdata} !== {1'b1, rdata, 1'b0, 128'h0}) begin
            errors++;
            $display("FAIL %s resp_if: got i=%b/%h d=%b/%h, want i=1/%h d=0/0",
                     tag, l2i_resp, l2i_rdata, l2d_resp, l2d_rdata, rdata);
         end
      end else begin
         if ({l2i_resp, l2i_rdata, l2d_resp, l2d_rdata} !== {1'b0, 128'h0, 1'b1, rdata}) begin
            errors++;
            $display("FAIL %s resp_mem: got i=%b/%h d=%b/%h, want i=0/0 d=1/%h",
                     tag, l2i_resp, l2i_rdata, l2d_resp, l2d_rdata, rdata);
         end
      end
      @(negedge clk);
      l2_resp = 1'b0; l2_rdata = '0; #1;
      checks++;
      if ({l2i_resp, l2d_resp, l2_read, l2_write, l2_address} !== '0) begin
         errors++;
         $display("FAIL %s idle_after_resp: got i=%b d=%b r=%b w=%b addr=%h, want all 0",
                  tag, l2i_resp, l2d_resp, l2_read, l2_write, l2_address);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      IF_address = '0; IF_read = 0; IF_write = 0; IF_wdata = '0;
      MEM_address = '0; MEM_read = 0; MEM_write = 0; MEM_wdata = '0;
      l2_resp = 0; l2_rdata = '0;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if ({l2i_resp, l2i_rdata, l2d_resp, l2d_rdata, l2_address, l2_read, l2_write, l2_wdata} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got r=%b w=%b addr=%h, want all 0", l2_read, l2_write, l2_address);
      end
      reset = 1'b0;
      // Reset in the middle of a MEM transaction.
      MEM_read = 1; MEM_address = 16'h2468;
      @(negedge clk); #1;
      checks++;
      if ({l2_read, l2_address} !== {1'b1, 16'h2468}) begin
         errors++;
         $display("FAIL reset_pre_grant: got r=%b addr=%h, want r=1 addr=2468", l2_read, l2_address);
      end
      l2_resp = 1'b1; l2_rdata = RD_3C;
      reset = 1'b1; #1;
      checks++;
      if ({l2i_resp, l2i_rdata, l2d_resp, l2d_rdata, l2_address, l2_read, l2_write, l2_wdata} !== '0) begin
         errors++;
         $display("FAIL reset_mid_serve: got d=%b r=%b addr=%h, want all 0", l2d_resp, l2_read, l2_address);
      end
      l2_resp = 0; l2_rdata = '0; MEM_read = 0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk); #1;
      checks++;
      if ({l2_read, l2_write} !== 2'b00) begin
         errors++;
         $display("FAIL reset_release_idle: got r=%b w=%b, want 0 0", l2_read, l2_write);
      end
   endtask

   task automatic test_if_read();
      IF_read = 1; IF_address = 16'h1230; #1;
      checks++;
      if (l2_read !== 1'b0) begin
         errors++;
         $display("FAIL if_read_no_early_strobe: got l2_read=%b, want 0", l2_read);
      end
      sb_q.push_back(mk(1, 16'h1230, 1, 0, 128'h0));
      sb_pop_grant("if_read", RD_A5, 1);
      IF_read = 0;
   endtask

   task automatic test_simultaneous();
      IF_read = 1; IF_address = 16'h1111;
      MEM_write = 1; MEM_address = 16'h4000; MEM_wdata = 128'h1;
      sb_q.push_back(mk(0, 16'h4000, 0, 1, 128'h1));
      sb_q.push_back(mk(1, 16'h1111, 1, 0, 128'h0));
      sb_pop_grant("simul_mem", RD_3C, 1);
      MEM_write = 0; MEM_wdata = '0;
      sb_pop_grant("simul_if", RD_A5, 1);
      IF_read = 0;
   endtask

   task automatic test_starvation();
      IF_read = 1; IF_address = 16'h1000;
      MEM_read = 1; MEM_address = 16'h2000;
      for (int i = 0; i < 4; i++) sb_q.push_back(mk(0, 16'h2000, 1, 0, 128'h0));
      sb_q.push_back(mk(1, 16'h1000, 1, 0, 128'h0));
      sb_q.push_back(mk(0, 16'h2000, 1, 0, 128'h0));
      for (int i = 0; i < 6; i++) sb_pop_grant($sformatf("starve_%0d", i), 128'(i + 7), 1);
      IF_read = 0; MEM_read = 0;
   endtask

   task automatic test_abort();
      IF_read = 1; IF_address = 16'h1230;
      @(negedge clk); #1;
      checks++;
      if ({l2_read, l2_address} !== {1'b1, 16'h1230}) begin
         errors++;
         $display("FAIL abort_grant: got r=%b addr=%h, want r=1 addr=1230", l2_read, l2_address);
      end
      IF_read = 0; #1;
      checks++;
      if (l2_read !== 1'b0) begin
         errors++;
         $display("FAIL abort_strobe_drop: got l2_read=%b, want 0", l2_read);
      end
      @(negedge clk);
      l2_resp = 1; l2_rdata = RD_A5; #1;
      checks++;
      if ({l2i_resp, l2d_resp, l2i_rdata, l2d_rdata} !== '0) begin
         errors++;
         $display("FAIL abort_late_resp: got i=%b d=%b, want 0 0", l2i_resp, l2d_resp);
      end
      @(negedge clk);
      l2_resp = 0; l2_rdata = '0; #1;
      checks++;
      if ({l2_read, l2_write} !== 2'b00) begin
         errors++;
         $display("FAIL abort_stay_idle: got r=%b w=%b, want 0 0", l2_read, l2_write);
      end
   endtask

   task automatic test_resp_isolation();
      MEM_read = 1; MEM_address = 16'h2222;
      IF_read = 1; IF_address = 16'h3333;
      sb_q.push_back(mk(0, 16'h2222, 1, 0, 128'h0));
      sb_q.push_back(mk(1, 16'h3333, 1, 0, 128'h0));
      sb_pop_grant("iso_mem", RD_3C, 1);
      MEM_read = 0;
      sb_pop_grant("iso_if", RD_A5, 1);
      IF_read = 0;
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d left, want 0", sb_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_if_read();
      test_simultaneous();
      test_starvation();
      test_abort();
      test_resp_isolation();
      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/l2_arbiter_fsm.md
Name: l2_arbiter_fsm

Overview:
- Sequential arbiter sharing the single L2 cache port between the IF (instruction) L1 cache and the MEM (data) L1 cache.
- Grants the port to one requester and locks the grant until L2 returns l2_resp, so a multi-cycle L2 transaction is never switched mid-flight.
- Default priority is MEM over IF. A starvation counter forces an IF grant after a bounded number of consecutive MEM grants.
- Sits between the two L1 caches and the L2 cache.

Parameters:
- STARVE_LIMIT, 4, number of consecutive MEM grants taken while IF is pending, after which the next grant is forced to IF (legal range 1..15).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- IF_address  input  16 (lc3b_word)  IF cache line address.
- IF_read  input  1  IF read request.
- IF_write  input  1  IF write request.
- IF_wdata  input  128 (lc3b_burst)  IF write burst.
- MEM_address  input  16  MEM cache line address.
- MEM_read  input  1  MEM read request.
- MEM_write  input  1  MEM write request.
- MEM_wdata  input  128  MEM write burst.
- l2_resp  input  1  L2 transaction complete.
- l2_rdata  input  128  L2 read burst.
- l2i_resp  output  1  response to IF cache.
- l2i_rdata  output  128  read data to IF cache.
- l2d_resp  output  1  response to MEM cache.
- l2d_rdata  output  128  read data to MEM cache.
- l2_address  output  16  address to L2.
- l2_read  output  1  read strobe to L2.
- l2_write  output  1  write strobe to L2.
- l2_wdata  output  128  write burst to L2.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset: state=IDLE, starve_cnt=0. All outputs are 0 while in IDLE (combinational decode from state).
- States: IDLE, SERVE_I, SERVE_D.
- Request terms: if_req = IF_read|IF_write; mem_req = MEM_read|MEM_write.
- IDLE transitions:
  - if_req && starve_cnt==STARVE_LIMIT -> SERVE_I.
  - else mem_req -> SERVE_D.
  - else if_req -> SERVE_I.
  - else stay in IDLE.
- Latency: a request first sampled in IDLE produces an L2 strobe in the following cycle. Minimum grant-to-grant gap is one IDLE cycle.
- SERVE_I outputs:
  - l2_read/l2_write/l2_address/l2_wdata = IF_* (live passthrough).
  - l2i_resp=l2_resp, l2i_rdata=l2_rdata.
  - l2d_resp=0, l2d_rdata=0.
- SERVE_D outputs: mirror of SERVE_I with MEM_* and l2d_*. The non-granted side's resp and rdata are 0.
- Leaving a SERVE state:
  - On l2_resp=1, go to IDLE next edge. The resp pulse is forwarded in the same cycle (combinational).
  - The granted requester must hold its request until resp. If it drops both read and write before resp (abort), go to IDLE next edge; strobes follow the live inputs, so they deassert immediately.
- starve_cnt (width 4) updates on each IDLE->SERVE_D transition:
  - if_req was high: starve_cnt = min(starve_cnt+1, STARVE_LIMIT) (saturating).
  - if_req was low: starve_cnt = 0.
- starve_cnt resets to 0 on every IDLE->SERVE_I transition.
- Simultaneous if_req and mem_req in IDLE: MEM wins unless starved.
- Requests arriving during SERVE_x are ignored until the next IDLE.
- l2_resp in IDLE is ignored: no resp is forwarded to either cache.
- One requester asserting both read and write is illegal. Both strobes pass through unchanged; the bench flags it.
- Reset asserted mid-transaction: immediate return to IDLE, all outputs 0, counter cleared.

Decomposition:
- lc3b_types holds:
  - lc3b_word and lc3b_burst (existing).
  - New enum arb_state_t {IDLE, SERVE_I, SERVE_D}.
  - Constant ARB_STARVE_W=4.
- One sub-module is natural: arb_starve_counter (saturating counter with clear/inc/limit compare).
- The FSM plus the output mux stay in the top module.

Test Plan:
- Reset mid SERVE_D with MEM_read=1 -> all outputs 0 immediately; after release with no requests, state IDLE, l2_read=0.
- IF_read=1, IF_address=0x1230 alone -> cycle+1: l2_read=1, l2_address=0x1230. L2 resp with l2_rdata=128'hA5.. -> l2i_resp=1 and l2i_rdata match that cycle; l2d_resp=0; IDLE next cycle.
- IF_read and MEM_write (MEM_address=0x4000, wdata=128'h1) both asserted in IDLE -> SERVE_D, l2_write=1, l2_address=0x4000. After resp, IF is granted on the next IDLE decision.
- MEM_read held continuously, IF_read held, STARVE_LIMIT=4 -> exactly 4 MEM grants, then 1 IF grant, then MEM again; never 5 consecutive MEM grants with IF pending.
- Granted IF drops IF_read before l2_resp -> l2_read=0 same cycle, IDLE next cycle; a late l2_resp in IDLE is not forwarded (l2i_resp=0, l2d_resp=0).
- l2_resp pulse while in SERVE_D with the IF request waiting -> l2i_resp stays 0, only l2d_resp=1.
